// File: rtl/gate_truth_sequencer_if.sv
// Bundle between gate_truth_sequencer and its controller / gate under test.
// ERR_W must match the sequencer's ERR_W parameter.
interface gate_truth_sequencer_if #(
  parameter int ERR_W = 4
);
  logic             start;
  logic             a_out;
  logic             b_out;
  logic             gate_in;
  logic             busy;
  logic             done;
  logic [ERR_W-1:0] err_cnt;
  logic             pass;

  modport master (
    output start, gate_in,
    input  a_out, b_out, busy, done, err_cnt, pass
  );

  modport slave (
    input  start, gate_in,
    output a_out, b_out, busy, done, err_cnt, pass
  );
endinterface

// File: rtl/gate_truth_sequencer.sv
// Drives A/B of a 2-input AND gate through 00,01,10,11 and checks its output.
// Checking (err_cnt/pass) exists only when GATE_CHECK_EN is defined.
//
//   state   | meaning
//   S_IDLE  | waiting for start, A/B held at 0
//   S_DRIVE | stepping combos, each held HOLD_CYCLES cycles
//   S_DONE  | one-cycle done pulse, then back to idle
module gate_truth_sequencer #(
  parameter int HOLD_CYCLES = 100,
  parameter int ERR_W       = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  gate_truth_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] hold_cnt;
  logic [15:0] hold_cnt_nxt;
  logic [1:0]  combo;
  logic [1:0]  combo_nxt;
  logic        last_hold;
  logic        start_ok;

  assign last_hold = (hold_cnt == HOLD_LAST);
  assign start_ok  = (state == S_IDLE) && bus.start;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      hold_cnt <= '0;
      combo    <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
      combo    <= combo_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    combo_nxt    = combo;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    bus.a_out    = 1'b0;
    bus.b_out    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_nxt    = S_DRIVE;
          hold_cnt_nxt = '0;
          combo_nxt    = '0;
        end
      end
      S_DRIVE: begin
        bus.busy  = 1'b1;
        bus.a_out = combo[1];
        bus.b_out = combo[0];
        if (last_hold) begin
          hold_cnt_nxt = '0;
          if (combo == 2'b11) begin
            state_nxt = S_DONE;
            combo_nxt = '0;
          end else begin
            combo_nxt = combo + 2'd1;
          end
        end else begin
          hold_cnt_nxt = hold_cnt + 16'd1;
        end
      end
      S_DONE: begin
        bus.done  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

`ifdef GATE_CHECK_EN
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  logic [ERR_W-1:0] err_cnt;
  logic [ERR_W-1:0] err_nxt;
  logic             pass_q;
  logic             sample;
  logic             mismatch;

  assign sample   = (state == S_DRIVE) && last_hold;
  assign mismatch = sample && (bus.gate_in != (combo[1] & combo[0]));

  always_comb begin
    err_nxt = err_cnt;
    if (mismatch && (err_cnt != ERR_MAX)) begin
      err_nxt = err_cnt + 1'b1;
    end
  end

  // pass uses err_nxt so the final combo's comparison is counted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt <= '0;
      pass_q  <= 1'b0;
    end else if (start_ok) begin
      err_cnt <= '0;
      pass_q  <= 1'b0;
    end else begin
      err_cnt <= err_nxt;
      if (sample && (combo == 2'b11)) begin
        pass_q <= (err_nxt == '0);
      end
    end
  end

  assign bus.err_cnt = err_cnt;
  assign bus.pass    = pass_q;
`else
  assign bus.err_cnt = '0;
  assign bus.pass    = 1'b0;
`endif

endmodule

// File: tb/tb_gate_truth_sequencer.sv
// Directed bench: dut0 runs HOLD_CYCLES=4/ERR_W=4, dut1 runs HOLD_CYCLES=1/ERR_W=1.
// Expected err_cnt/pass follow GATE_CHECK_EN; with it undefined both stay 0.
module tb_gate_truth_sequencer;

`ifdef GATE_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   mode0;
  int   mode1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  gate_truth_sequencer_if #(.ERR_W(4)) if0 ();
  gate_truth_sequencer_if #(.ERR_W(1)) if1 ();

  gate_truth_sequencer #(.HOLD_CYCLES(4), .ERR_W(4)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0.slave)
  );

  gate_truth_sequencer #(.HOLD_CYCLES(1), .ERR_W(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  // mode: 0 = correct AND, 1 = stuck-at-1, 2 = stuck-at-0
  always_comb begin
    case (mode0)
      0:       if0.gate_in = if0.a_out & if0.b_out;
      1:       if0.gate_in = 1'b1;
      default: if0.gate_in = 1'b0;
    endcase
    case (mode1)
      0:       if1.gate_in = if1.a_out & if1.b_out;
      1:       if1.gate_in = 1'b1;
      default: if1.gate_in = 1'b0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] status(input bit sel);
    return sel ? {if1.busy, if1.done, if1.a_out, if1.b_out}
               : {if0.busy, if0.done, if0.a_out, if0.b_out};
  endfunction

  function automatic logic [31:0] errv(input bit sel);
    return sel ? 32'(if1.err_cnt) : 32'(if0.err_cnt);
  endfunction

  function automatic logic passv(input bit sel);
    return sel ? if1.pass : if0.pass;
  endfunction

  task automatic set_start(input bit sel, input logic v);
    if (sel) if1.start = v;
    else     if0.start = v;
  endtask

  // Start pulse in cycle 0; checks cycles 1..4h+2 against the expected timeline.
  task automatic run(input bit sel, input int h, input int mode, input int e_err,
                     input bit e_pass, input bit keep_start);
    logic [3:0] exp;
    if (sel) mode1 = mode;
    else     mode0 = mode;
    @(negedge clk);
    set_start(sel, 1'b1);
    for (int c = 1; c <= 4*h + 2; c++) begin
      @(negedge clk);
      if (!keep_start) set_start(sel, 1'b0);
      if (c <= 4*h)          exp = {2'b10, 2'((c-1)/h)};
      else if (c == 4*h + 1) exp = 4'b0100;
      else                   exp = 4'b0000;
      chk($sformatf("seq_c%0d", c), 32'(status(sel)), 32'(exp));
      if (c == 1) chk("clr_on_start", {errv(sel), 31'd0, passv(sel)}, 32'd0);
      if (c > 4*h) begin
        chk($sformatf("err_c%0d", c), errv(sel), CHK_EN ? 32'(e_err) : 32'd0);
        chk($sformatf("pass_c%0d", c), 32'(passv(sel)), CHK_EN ? 32'(e_pass) : 32'd0);
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int ndone;
    rst_n    = 1'b0;
    mode0    = 0;
    mode1    = 0;
    if0.start = 1'b0;
    if1.start = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_status0", 32'(status(0)), 32'd0);
    chk("rst_status1", 32'(status(1)), 32'd0);
    chk("rst_err0", {errv(0), 31'd0, passv(0)}, 32'd0);
    if1.start = 1'b0;
    rst_n = 1'b1;

    run(0, 4, 0, 0, 1'b1, 1'b0);
    run(0, 4, 1, 3, 1'b0, 1'b0);
    run(0, 4, 2, 1, 1'b0, 1'b0);
    run(1, 1, 1, 1, 1'b0, 1'b0);
    run(1, 1, 0, 0, 1'b1, 1'b0);

    // start held high the whole run: single done, re-accepted once IDLE is reached
    run(0, 4, 0, 0, 1'b1, 1'b1);
    @(negedge clk);
    chk("reaccept_busy", 32'(status(0)), 32'b1000);
    if0.start = 1'b0;
    do_reset();

    // reset during combo 10 with a stuck-at-1 gate
    mode0 = 1;
    @(negedge clk);
    if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    repeat (8) @(negedge clk);
    chk("mid_combo10", 32'(status(0)), 32'b1010);
    chk("mid_err", errv(0), CHK_EN ? 32'd2 : 32'd0);
    rst_n = 1'b0;
    if0.start = 1'b1;
    @(negedge clk);
    chk("mid_rst_status", 32'(status(0)), 32'd0);
    chk("mid_rst_err", {errv(0), 31'd0, passv(0)}, 32'd0);
    if0.start = 1'b0;
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if0.done || if0.busy) ndone++;
    end
    chk("no_done_after_rst", 32'(ndone), 32'd0);
    run(0, 4, 0, 0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
